// File: rtl/tx_sample_pacer.sv
// Paces a transmitter: periodic sample tick, AM sample FIFO drained one word per tick,
// and frequency/control words that are applied on sample boundaries only.
module tx_sample_pacer #(
  parameter int DIVIDE     = 1250,
  parameter int FIFO_DEPTH = 8,
  parameter int AM_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         input_tx_freq,
  input  logic                input_tx_freq_stb,
  output logic                input_tx_freq_ack,
  input  logic [31:0]         input_tx_am,
  input  logic                input_tx_am_stb,
  output logic                input_tx_am_ack,
  input  logic [31:0]         input_tx_ctl,
  input  logic                input_tx_ctl_stb,
  output logic                input_tx_ctl_ack,
  output logic [31:0]         freq_word,
  output logic [AM_WIDTH-1:0] am_level,
  output logic                tx_enable,
  output logic                sample_tick,
  output logic                underrun,
  output logic [6:0]          fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [15:0]      TICK_LAST = 16'(DIVIDE - 1);
  localparam logic [6:0]       FIFO_FULL = 7'(FIFO_DEPTH);

  logic [15:0]         tick_cnt;
  logic [15:0]         tick_cnt_next;
  logic                tick_next;
  logic [31:0]         freq_pending;
  logic [AM_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [6:0]          count_next;
  logic                freq_xfer;
  logic                am_xfer;
  logic                ctl_xfer;
  logic                pop;
  logic                pop_next;
  logic                enable_next;
  logic                am_ack_next;
  logic                unused_bits;

  assign unused_bits = ^{input_tx_ctl, input_tx_am};
  assign sample_tick = (tick_cnt == TICK_LAST);

  // The AM ack is registered, so it looks one cycle ahead: it may assert into a full
  // FIFO only when the following cycle is known to pop a word.
  always_comb begin
    freq_xfer     = input_tx_freq_stb & input_tx_freq_ack;
    am_xfer       = input_tx_am_stb & input_tx_am_ack;
    ctl_xfer      = input_tx_ctl_stb & input_tx_ctl_ack;
    tick_cnt_next = sample_tick ? 16'd0 : tick_cnt + 16'd1;
    tick_next     = (tick_cnt_next == TICK_LAST);
    enable_next   = ctl_xfer ? input_tx_ctl[0] : tx_enable;
    pop           = sample_tick & tx_enable & (fifo_count != 7'd0);
    count_next    = fifo_count;
    if (am_xfer && !pop) begin
      count_next = fifo_count + 7'd1;
    end else if (pop && !am_xfer) begin
      count_next = fifo_count - 7'd1;
    end
    pop_next    = tick_next & enable_next & (count_next != 7'd0);
    am_ack_next = input_tx_am_stb & ~input_tx_am_ack & ((count_next != FIFO_FULL) | pop_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt          <= '0;
      input_tx_freq_ack <= 1'b0;
      input_tx_am_ack   <= 1'b0;
      input_tx_ctl_ack  <= 1'b0;
      freq_pending      <= '0;
      freq_word         <= '0;
      tx_enable         <= 1'b0;
      underrun          <= 1'b0;
      am_level          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
    end else begin
      tick_cnt          <= tick_cnt_next;
      input_tx_freq_ack <= input_tx_freq_stb & ~input_tx_freq_ack;
      input_tx_am_ack   <= am_ack_next;
      input_tx_ctl_ack  <= input_tx_ctl_stb & ~input_tx_ctl_ack;
      tx_enable         <= enable_next;
      fifo_count        <= count_next;
      if (freq_xfer) begin
        freq_pending <= input_tx_freq;
      end
      if (sample_tick) begin
        freq_word <= freq_pending;
      end
      // A starving tick takes priority over a clear arriving on the same edge.
      if (sample_tick && tx_enable && fifo_count == 7'd0) begin
        underrun <= 1'b1;
      end else if (ctl_xfer && input_tx_ctl[1]) begin
        underrun <= 1'b0;
      end
      if (!tx_enable) begin
        am_level <= '0;
      end else if (pop) begin
        am_level <= fifo_mem[rd_ptr];
      end
      if (am_xfer) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (am_xfer && !rst) begin
      fifo_mem[wr_ptr] <= input_tx_am[AM_WIDTH-1:0];
    end
  end

endmodule

// File: doc/tx_sample_pacer.md
TX_SAMPLE_PACER -- requirements
Module: tx_sample_pacer

Interface
REQ-001 SHALL have parameter DIVIDE, default 1250, clk cycles per sample period (valid range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, depth of the AM sample FIFO (power of 2, 2..64).
REQ-003 SHALL have parameter AM_WIDTH, default 8, width of am_level.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-007 SHALL have ports input_tx_freq / _stb / _ack  in / in / out  32 / 1 / 1  NCO frequency word stream (from output_tx_freq).
REQ-008 SHALL have ports input_tx_am / _stb / _ack  in / in / out  32 / 1 / 1  AM sample stream (from output_tx_am).
REQ-009 SHALL have ports input_tx_ctl / _stb / _ack  in / in / out  32 / 1 / 1  control word stream (from output_tx_ctl).
REQ-010 SHALL have port freq_word  out  32  active frequency word to the NCO.
REQ-011 SHALL have port am_level  out  AM_WIDTH  active amplitude to the modulator.
REQ-012 SHALL have port tx_enable  out  1  transmitter enable.
REQ-013 SHALL have port sample_tick  out  1  one-cycle pulse per sample period.
REQ-014 SHALL have port underrun  out  1  sticky AM FIFO underrun flag.
REQ-015 SHALL have port fifo_count  out  7  current AM FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-016 Every _ack SHALL be registered; a word transfers on the rising edge where stb and ack are both high; ack SHALL drop the cycle after a transfer (max one word per 2 cycles per stream).
REQ-017 input_tx_am_ack SHALL assert only when stb is high and the FIFO is not full, counting a same-cycle pop; when full, ack SHALL stay low and the producer stalls.
REQ-018 input_tx_freq_ack and input_tx_ctl_ack SHALL assert whenever their stb is high (never stall).
REQ-019 The tick counter SHALL count 0..DIVIDE-1 and wrap to 0; sample_tick SHALL be high exactly in the cycle the count equals DIVIDE-1; the counter SHALL run regardless of tx_enable.
REQ-020 An accepted freq word SHALL load a pending register; freq_word SHALL update from pending on the cycle after the next sample_tick, never mid-period. A later write before the tick SHALL overwrite pending (last wins).
REQ-021 An accepted ctl word: bit0 SHALL drive tx_enable from the next cycle; bit1=1 SHALL clear underrun; bits 31:2 SHALL be ignored.
REQ-022 On sample_tick with tx_enable=1 and FIFO non-empty: pop one word; am_level SHALL equal word[AM_WIDTH-1:0] from the next cycle.
REQ-023 On sample_tick with tx_enable=1 and FIFO empty: am_level SHALL hold its value and underrun SHALL set.
REQ-024 With tx_enable=0: am_level SHALL be 0 from the next cycle; no pops; underrun SHALL not set; the FIFO SHALL keep accepting until full.
REQ-025 When a push and a pop occur in the same cycle, fifo_count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-026 When an underrun set and a ctl bit1 clear occur in the same cycle, the set SHALL win.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-028 While rst is high, all acks, sample_tick, tx_enable, underrun, freq_word, the pending freq register, am_level, fifo_count, the FIFO pointers and the tick counter SHALL be 0.
REQ-029 rst asserted mid-transfer or mid-period SHALL discard FIFO contents and the pending freq word; the first sample_tick SHALL occur DIVIDE cycles after rst deasserts.

Verification
REQ-030 DIVIDE=4, reset released: sample_tick SHALL pulse on cycles 4, 8, 12 after release, exactly one cycle wide each.
REQ-031 ctl=1, push AM words 0x11, 0x22, 0x33: am_level SHALL be 0x11, 0x22, 0x33 after successive ticks, then hold 0x33 with underrun=1; ctl=0x3 SHALL clear underrun and keep tx_enable=1.
REQ-032 Push 9 AM words with FIFO_DEPTH=8 and tx_enable=0: fifo_count SHALL be 8 and the 9th ack SHALL stay low until tx_enable=1 and a tick pops a word.
REQ-033 Write freq 0x1000 then 0x2000 within one period: freq_word SHALL stay at its old value until after the tick, then become 0x2000; 0x1000 SHALL never appear.
REQ-034 With FIFO full, push and tick in the same cycle: fifo_count SHALL stay 8 and pop order SHALL match push order.
REQ-035 Assert rst for 1 cycle with 5 words queued and a pending freq write: all outputs SHALL be 0 and fifo_count 0, and freq_word SHALL stay 0 after the next tick.
